bus_rr_fifo_arbiter: RTL and testbench

- Parametrised successor to the single-stage bus generator/arbiter.
- Accepts packets from DRIVERS independent sources, each buffered in its own DEPTH-entry FIFO.
- Grants a shared bus round-robin, one packet per cycle, and delivers each packet to one addressed destination or to all other drivers (broadcast).
- Sits between the per-driver agents and the shared interconnect. It is the DUT for the next round of the bus verification environment.

---
 rtl/bus_rr_fifo_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_bus_rr_fifo_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_fifo_arbiter.sv
// Multi-driver bus arbiter: per-driver FIFOs, round-robin grant of one packet per cycle,
// unicast/broadcast delivery. Optional statistics counters are enabled by `define BUS_STATS_EN.
module bus_rr_fifo_arbiter #(
    parameter int              BITS    = 8,
    parameter int              DEPTH   = 4,
    parameter int              DRIVERS = 4,
    parameter int              PCKG    = 16,
    parameter logic [BITS-1:0] BROD    = BITS'(8'hFF)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DRIVERS-1:0]         push,
    input  logic [DRIVERS*PCKG-1:0]    din,
    output logic [DRIVERS-1:0]         full,
    output logic [DRIVERS-1:0]         pndng,
    output logic [DRIVERS-1:0]         ovf,
    output logic [PCKG-1:0]            bus_data,
    output logic [$clog2(DRIVERS)-1:0] bus_src,
    output logic [DRIVERS-1:0]         dvld,
    output logic                       err,
    output logic [15:0]                xfer_cnt,
    output logic [15:0]                drop_cnt
);

    localparam int SW  = $clog2(DRIVERS);
    localparam int SW1 = SW + 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    // Reset asserts asynchronously but leaves reset only on a clock edge.
    logic [1:0] rst_sync_reg;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    logic [DRIVERS*PCKG-1:0] head_flat;
    logic [SW-1:0]           rr_ptr_reg;
    logic [SW-1:0]           rr_ptr_next;
    logic                    grant_valid;
    logic [SW-1:0]           grant_idx;
    logic [SW1-1:0]          scan_idx;
    logic [PCKG-1:0]         grant_pkt;
    logic [BITS-1:0]         grant_dst;
    logic [DRIVERS-1:0]      dvld_next;
    logic                    err_next;

    logic [PCKG-1:0]         bus_data_reg;
    logic [SW-1:0]           bus_src_reg;
    logic [DRIVERS-1:0]      dvld_reg;
    logic                    err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DRIVERS; gi++) begin : g_fifo
            logic [PCKG-1:0] mem [DEPTH];
            logic [PW-1:0]   wr_ptr_reg;
            logic [PW-1:0]   rd_ptr_reg;
            logic [CW-1:0]   count_reg;
            logic            ovf_bit_reg;
            logic            wr_en;
            logic            rd_en;

            assign full[gi]  = (count_reg == CW'(DEPTH));
            assign pndng[gi] = (count_reg != '0);
            assign ovf[gi]   = ovf_bit_reg;
            // full is pre-edge state, so a push racing a pop on a full FIFO is dropped.
            assign wr_en     = push[gi] & ~full[gi];
            assign rd_en     = grant_valid & (grant_idx == SW'(gi));

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wr_ptr_reg] <= din[gi*PCKG +: PCKG];
                end
            end

            assign head_flat[gi*PCKG +: PCKG] = mem[rd_ptr_reg];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg  <= '0;
                    rd_ptr_reg  <= '0;
                    count_reg   <= '0;
                    ovf_bit_reg <= 1'b0;
                end else begin
                    if (wr_en) begin
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (rd_en) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    end
                    case ({wr_en, rd_en})
                        2'b10:   count_reg <= count_reg + CW'(1);
                        2'b01:   count_reg <= count_reg - CW'(1);
                        default: count_reg <= count_reg;
                    endcase
                    ovf_bit_reg <= push[gi] & full[gi];
                end
            end
        end
    endgenerate

    // Round-robin search starting at rr_ptr, wrapping modulo DRIVERS.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < DRIVERS; k++) begin
            scan_idx = {1'b0, rr_ptr_reg} + SW1'(k);
            if (scan_idx >= SW1'(DRIVERS)) begin
                scan_idx = scan_idx - SW1'(DRIVERS);
            end
            if (!grant_valid && pndng[scan_idx[SW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx[SW-1:0];
            end
        end
    end

    always_comb begin
        grant_pkt   = head_flat[grant_idx*PCKG +: PCKG];
        grant_dst   = grant_pkt[PCKG-1 -: BITS];
        dvld_next   = '0;
        err_next    = 1'b0;
        rr_ptr_next = rr_ptr_reg;
        if (grant_dst < BITS'(DRIVERS)) begin
            dvld_next = DRIVERS'(1) << grant_dst;
        end else if (grant_dst == BROD) begin
            dvld_next = ~(DRIVERS'(1) << grant_idx);
        end else begin
            err_next = 1'b1;
        end
        if (grant_valid) begin
            rr_ptr_next = (grant_idx == SW'(DRIVERS - 1)) ? '0 : grant_idx + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_data_reg <= '0;
            bus_src_reg  <= '0;
            dvld_reg     <= '0;
            err_reg      <= 1'b0;
            rr_ptr_reg   <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (grant_valid) begin
                bus_data_reg <= grant_pkt;
                bus_src_reg  <= grant_idx;
                dvld_reg     <= dvld_next;
                err_reg      <= err_next;
            end else begin
                dvld_reg <= '0;
                err_reg  <= 1'b0;
            end
        end
    end

    assign bus_data = bus_data_reg;
    assign bus_src  = bus_src_reg;
    assign dvld     = dvld_reg;
    assign err      = err_reg;

`ifdef BUS_STATS_EN
    logic [15:0] xfer_cnt_reg;
    logic [15:0] drop_cnt_reg;
    logic [16:0] xfer_sum;
    logic [16:0] drop_sum;
    logic [16:0] drop_inc;

    always_comb begin
        drop_inc = {16'b0, err_reg};
        for (int k = 0; k < DRIVERS; k++) begin
            drop_inc = drop_inc + 17'(ovf[k]);
        end
        xfer_sum = {1'b0, xfer_cnt_reg} + 17'(grant_valid & ~err_next);
        drop_sum = {1'b0, drop_cnt_reg} + drop_inc;
    end

    // Saturating counters: the 17th bit flags a wrap that must be clamped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            xfer_cnt_reg <= xfer_sum[16] ? 16'hFFFF : xfer_sum[15:0];
            drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign xfer_cnt = xfer_cnt_reg;
    assign drop_cnt = drop_cnt_reg;
`else
    assign xfer_cnt = 16'h0000;
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_rr_fifo_arbiter.sv
// Scoreboard bench for bus_rr_fifo_arbiter: directed stimulus queues expected bus outputs,
// a negedge monitor pops and compares every delivery or error pulse.
module tb_bus_rr_fifo_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  push;
    logic [63:0] din;
    logic [3:0]  full;
    logic [3:0]  pndng;
    logic [3:0]  ovf;
    logic [15:0] bus_data;
    logic [1:0]  bus_src;
    logic [3:0]  dvld;
    logic        err;
    logic [15:0] xfer_cnt;
    logic [15:0] drop_cnt;

    int checks;
    int failures;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  src;
        logic [3:0]  dvld;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    bus_rr_fifo_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      (din),
        .full     (full),
        .pndng    (pndng),
        .ovf      (ovf),
        .bus_data (bus_data),
        .bus_src  (bus_src),
        .dvld     (dvld),
        .err      (err),
        .xfer_cnt (xfer_cnt),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_out(input logic [15:0] d, input logic [1:0] s,
                              input logic [3:0] v, input logic e);
        exp_q.push_back({d, s, v, e});
    endtask

    // One clock edge with the given push strobes and packet slices.
    task automatic step(input logic [3:0] p, input logic [63:0] d);
        push = p;
        din  = d;
        @(posedge clk);
        #1;
        push = 4'b0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_full",     32'(full),     32'h0);
        check("rst_pndng",    32'(pndng),    32'h0);
        check("rst_ovf",      32'(ovf),      32'h0);
        check("rst_bus_data", 32'(bus_data), 32'h0);
        check("rst_bus_src",  32'(bus_src),  32'h0);
        check("rst_dvld",     32'(dvld),     32'h0);
        check("rst_err",      32'(err),      32'h0);
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with a delivery or error pulse consumes one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dvld !== 4'b0000 || err !== 1'b0) begin
                $display("txn src=%0d data=%h dvld=%b err=%b", bus_src, bus_data, dvld, err);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual src=%0d data=%h dvld=%b err=%b required=none",
                             bus_src, bus_data, dvld, err);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus_data, bus_src, dvld, err} !== e) begin
                        failures++;
                        $display("FAIL scoreboard actual src=%0d data=%h dvld=%b err=%b required src=%0d data=%h dvld=%b err=%b",
                                 bus_src, bus_data, dvld, err, e.src, e.data, e.dvld, e.err);
                    end
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        push     = 4'b0000;
        din      = 64'h0;
        #2;
        do_reset();

        // Single unicast packet from driver 1 to driver 2.
        expect_out(16'h02AB, 2'd1, 4'b0100, 1'b0);
        step(4'b0010, {16'h0000, 16'h0000, 16'h02AB, 16'h0000});
        check("single_pndng", 32'(pndng), 32'h2);
        step(4'b0000, 64'h0);
        step(4'b0000, 64'h0);

        // Broadcast from driver 2 reaches everyone but the sender.
        expect_out(16'hFF55, 2'd2, 4'b1011, 1'b0);
        step(4'b0100, {16'h0000, 16'hFF55, 32'h0});
        step(4'b0000, 64'h0);
        step(4'b0000, 64'h0);

        // Invalid destination from driver 3: error pulse, packet consumed.
        expect_out(16'h0711, 2'd3, 4'b0000, 1'b1);
        step(4'b1000, {16'h0711, 48'h0});
        step(4'b0000, 64'h0);
        check("err_pndng", 32'(pndng), 32'h0);
        step(4'b0000, 64'h0);
        step(4'b0000, 64'h0);
`ifdef BUS_STATS_EN
        check("stats_xfer_a", 32'(xfer_cnt), 32'd2);
        check("stats_drop_a", 32'(drop_cnt), 32'd1);
`else
        check("stats_xfer_a", 32'(xfer_cnt), 32'd0);
        check("stats_drop_a", 32'(drop_cnt), 32'd0);
`endif

        // Fairness: two packets per driver, grant order 0,1,2,3,0,1,2,3.
        do_reset();
        expect_out(16'h0110, 2'd0, 4'b0010, 1'b0);
        expect_out(16'h0211, 2'd1, 4'b0100, 1'b0);
        expect_out(16'h0312, 2'd2, 4'b1000, 1'b0);
        expect_out(16'h0013, 2'd3, 4'b0001, 1'b0);
        expect_out(16'h0220, 2'd0, 4'b0100, 1'b0);
        expect_out(16'h0321, 2'd1, 4'b1000, 1'b0);
        expect_out(16'h0022, 2'd2, 4'b0001, 1'b0);
        expect_out(16'h0123, 2'd3, 4'b0010, 1'b0);
        step(4'b1111, {16'h0013, 16'h0312, 16'h0211, 16'h0110});
        check("fair_pndng_loaded", 32'(pndng), 32'hF);
        step(4'b1111, {16'h0123, 16'h0022, 16'h0321, 16'h0220});
        repeat (7) step(4'b0000, 64'h0);
        check("fair_pndng_drained", 32'(pndng), 32'h0);

        // Overflow on driver 0 while drivers 1-3 compete (rr_ptr is 0 here).
        expect_out(16'h02D0, 2'd1, 4'b0100, 1'b0);
        expect_out(16'hFFE0, 2'd2, 4'b1011, 1'b0);
        expect_out(16'h01B0, 2'd3, 4'b0010, 1'b0);
        expect_out(16'h00C0, 2'd0, 4'b0001, 1'b0);
        expect_out(16'h02D1, 2'd1, 4'b0100, 1'b0);
        expect_out(16'hFFE1, 2'd2, 4'b1011, 1'b0);
        expect_out(16'h01B1, 2'd3, 4'b0010, 1'b0);
        expect_out(16'h00C1, 2'd0, 4'b0001, 1'b0);
        expect_out(16'h02D2, 2'd1, 4'b0100, 1'b0);
        expect_out(16'hFFE2, 2'd2, 4'b1011, 1'b0);
        expect_out(16'h01B2, 2'd3, 4'b0010, 1'b0);
        expect_out(16'h00C2, 2'd0, 4'b0001, 1'b0);
        expect_out(16'h00C3, 2'd0, 4'b0001, 1'b0);
        expect_out(16'h00C4, 2'd0, 4'b0001, 1'b0);
        step(4'b1110, {16'h01B0, 16'hFFE0, 16'h02D0, 16'h0000});
        step(4'b1111, {16'h01B1, 16'hFFE1, 16'h02D1, 16'h00C0});
        step(4'b1111, {16'h01B2, 16'hFFE2, 16'h02D2, 16'h00C1});
        step(4'b0001, {48'h0, 16'h00C2});
        check("ovf_full_c3", 32'(full), 32'h0);
        step(4'b0001, {48'h0, 16'h00C3});
        check("ovf_full_c3_popped", 32'(full), 32'h0);
        step(4'b0001, {48'h0, 16'h00C4});
        check("ovf_full_set", 32'(full), 32'h1);
        check("ovf_quiet", 32'(ovf), 32'h0);
        step(4'b0001, {48'h0, 16'h00C5});
        check("ovf_pulse", 32'(ovf), 32'h1);
        check("ovf_full_held", 32'(full), 32'h1);
        step(4'b0000, 64'h0);
        check("ovf_pulse_end", 32'(ovf), 32'h0);
        repeat (9) step(4'b0000, 64'h0);
        check("ovf_pndng_drained", 32'(pndng), 32'h0);
`ifdef BUS_STATS_EN
        check("stats_xfer_b", 32'(xfer_cnt), 32'd22);
        check("stats_drop_b", 32'(drop_cnt), 32'd1);
`else
        check("stats_xfer_b", 32'(xfer_cnt), 32'd0);
        check("stats_drop_b", 32'(drop_cnt), 32'd0);
`endif

        // Asynchronous reset mid-stream (rr_ptr is 1 here).
        expect_out(16'h0051, 2'd1, 4'b0001, 1'b0);
        step(4'b0111, {16'h0000, 16'h0352, 16'h0051, 16'h0150});
        step(4'b0111, {16'h0000, 16'h0362, 16'h0061, 16'h0160});
        check("mid_pndng", 32'(pndng), 32'h7);
        check("mid_bus_data", 32'(bus_data), 32'h0051);
        do_reset();
        repeat (6) step(4'b0000, 64'h0);
        check("post_rst_pndng", 32'(pndng), 32'h0);

        repeat (2) step(4'b0000, 64'h0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
